param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter_pkg.sv | 11 +
 rtl/counter_next_val.sv | 43 ++++
 rtl/param_updown_counter.sv | 84 ++++++++
 tb/tb_param_updown_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
// Mode and direction encodings used by the top and its next-value logic.
package param_updown_counter_pkg;

    localparam bit CNT_MODE_WRAP = 1'b0;
    localparam bit CNT_MODE_SAT  = 1'b1;

    localparam bit CNT_DIR_DOWN  = 1'b0;
    localparam bit CNT_DIR_UP    = 1'b1;

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count logic for one enabled step, with boundary flags.
// The boundary is tested before the step so no value ever exceeds WIDTH bits.
module counter_next_val
    import param_updown_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [31:0] MAX_COUNT = 32'd9,
    parameter bit          SATURATE  = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up_dn,
    output logic [WIDTH-1:0] nxt,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf_hit,
    output logic             unf_hit
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

    assign at_max  = (cnt == MAX_V);
    assign at_min  = (cnt == '0);
    assign ovf_hit = (up_dn == CNT_DIR_UP) & at_max;
    assign unf_hit = (up_dn == CNT_DIR_DOWN) & at_min;

    always_comb begin
        nxt = cnt;
        if (up_dn == CNT_DIR_UP) begin
            if (!at_max) begin
                nxt = cnt + 1'b1;
            end else if (SATURATE == CNT_MODE_WRAP) begin
                nxt = '0;
            end
        end else begin
            if (!at_min) begin
                nxt = cnt - 1'b1;
            end else if (SATURATE == CNT_MODE_WRAP) begin
                nxt = MAX_V;
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down modulus counter with wrap/saturate, tc and ovf/unf pulses.
// tc is combinational so it can drive the enable of a cascaded stage.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter logic [31:0] MAX_COUNT = 32'd9,
    parameter bit          SATURATE  = CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] d_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] ld_val;
    logic             at_max, at_min;
    logic             ovf_hit, unf_hit;

    counter_next_val #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT),
        .SATURATE  (SATURATE)
    ) u_next (
        .cnt     (cnt_q),
        .up_dn   (up_dn),
        .nxt     (step_val),
        .at_max  (at_max),
        .at_min  (at_min),
        .ovf_hit (ovf_hit),
        .unf_hit (unf_hit)
    );

    // A full-range modulus can never be exceeded, so the clamp is elided.
    if (MAX_V == {WIDTH{1'b1}}) begin : g_no_clamp
        assign ld_val = d_in;
    end else begin : g_clamp
        assign ld_val = (d_in > MAX_V) ? MAX_V : d_in;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load) begin
            cnt_d = ld_val;
        end else if (en) begin
            cnt_d = step_val;
            ovf_d = ovf_hit;
            unf_d = unf_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign d_out = cnt_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tc    = en & ((up_dn & at_max) | (~up_dn & at_min));

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: three configurations share one stimulus
// stream and are checked against an integer-arithmetic reference model.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic [7:0] d_in = 8'd0;

    logic [3:0] q0, q1;
    logic [7:0] q2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;
    logic       unf0, unf1, unf2;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(32'd9), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset(reset), .load(load), .d_in(d_in[3:0]), .en(en),
        .up_dn(up_dn), .d_out(q0), .tc(tc0), .ovf(ovf0), .unf(unf0)
    );

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(32'd9), .SATURATE(1'b1)) u1 (
        .clk(clk), .reset(reset), .load(load), .d_in(d_in[3:0]), .en(en),
        .up_dn(up_dn), .d_out(q1), .tc(tc1), .ovf(ovf1), .unf(unf1)
    );

    param_updown_counter #(.WIDTH(8), .MAX_COUNT(32'd255), .SATURATE(1'b0)) u2 (
        .clk(clk), .reset(reset), .load(load), .d_in(d_in), .en(en),
        .up_dn(up_dn), .d_out(q2), .tc(tc2), .ovf(ovf2), .unf(unf2)
    );

    int n_cmp = 0;
    int n_err = 0;

    int MAXS [3] = '{9, 9, 255};
    bit SATS [3] = '{1'b0, 1'b1, 1'b0};
    int MASKS[3] = '{15, 15, 255};

    int m_cnt[3];
    bit m_ovf[3];
    bit m_unf[3];
    bit mvalid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_q(input int i);
        case (i)
            0:       return {28'd0, q0};
            1:       return {28'd0, q1};
            default: return {24'd0, q2};
        endcase
    endfunction

    function automatic logic got_tc(input int i);
        case (i)
            0:       return tc0;
            1:       return tc1;
            default: return tc2;
        endcase
    endfunction

    function automatic logic got_ovf(input int i);
        case (i)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    function automatic logic got_unf(input int i);
        case (i)
            0:       return unf0;
            1:       return unf1;
            default: return unf2;
        endcase
    endfunction

    // Reference: counting modulo (MAX+1) for wrap, min/max clipping for saturate.
    task automatic model_step(input int i, input bit r, input bit l,
                              input int din, input bit e, input bit u);
        int m, c, v;
        m = MAXS[i];
        c = m_cnt[i];
        m_ovf[i] = 1'b0;
        m_unf[i] = 1'b0;
        if (r) begin
            c = 0;
        end else if (l) begin
            v = din & MASKS[i];
            c = (v > m) ? m : v;
        end else if (e) begin
            if (u) begin
                m_ovf[i] = (c == m);
                c = SATS[i] ? ((c + 1 > m) ? m : c + 1) : (c + 1) % (m + 1);
            end else begin
                m_unf[i] = (c == 0);
                c = SATS[i] ? ((c - 1 < 0) ? 0 : c - 1) : (c + m) % (m + 1);
            end
        end
        m_cnt[i] = c;
    endtask

    task automatic cyc(input bit r, input bit l, input int din,
                       input bit e, input bit u);
        bit exp_tc;
        @(negedge clk);
        reset = r;
        load  = l;
        d_in  = din[7:0];
        en    = e;
        up_dn = u;
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                exp_tc = e && (u ? (m_cnt[i] == MAXS[i]) : (m_cnt[i] == 0));
                chk($sformatf("tc%0d", i), {31'd0, got_tc(i)}, {31'd0, exp_tc});
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, l, din, e, u);
        if (r) mvalid = 1'b1;
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("q%0d", i), got_q(i), m_cnt[i]);
                chk($sformatf("ovf%0d", i), {31'd0, got_ovf(i)}, {31'd0, m_ovf[i]});
                chk($sformatf("unf%0d", i), {31'd0, got_unf(i)}, {31'd0, m_unf[i]});
            end
        end
    endtask

    initial begin
        // reset, then load 3 and count up through the 9->0 wrap
        cyc(1, 0, 0, 0, 0);
        chk("rst_q0", got_q(0), 32'd0);
        chk("rst_q2", got_q(2), 32'd0);
        cyc(0, 1, 3, 0, 1);
        chk("ld3_q0", got_q(0), 32'd3);
        for (int k = 0; k < 7; k++) cyc(0, 0, 0, 1, 1);
        chk("wrap_q0", got_q(0), 32'd0);
        chk("wrap_ovf0", {31'd0, ovf0}, 32'd1);
        chk("sat_q1", got_q(1), 32'd9);
        cyc(0, 0, 0, 1, 1);
        chk("ovf0_drop", {31'd0, ovf0}, 32'd0);

        // down from 1 through 0 -> 9
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("dwrap_q0", got_q(0), 32'd9);
        chk("dwrap_unf0", {31'd0, unf0}, 32'd1);

        // saturate hold at 9, then reverse
        cyc(0, 1, 8, 0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1);
        chk("sathold_ovf1", {31'd0, ovf1}, 32'd1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("satdn_q1", got_q(1), 32'd7);

        // clamp and load-over-count priority
        cyc(0, 1, 11, 0, 1);
        chk("clamp_q0", got_q(0), 32'd9);
        chk("noclamp_q2", got_q(2), 32'd11);
        cyc(0, 1, 2, 1, 1);
        chk("ldwin_q0", got_q(0), 32'd2);

        // hold at 5, then reset beats load
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("hold_q0", got_q(0), 32'd5);
        cyc(1, 1, 7, 1, 1);
        chk("rstld_q0", got_q(0), 32'd0);

        // 8-bit full-range boundaries
        cyc(0, 1, 255, 0, 1);
        cyc(0, 0, 0, 1, 1);
        chk("w8_wrap_q2", got_q(2), 32'd0);
        cyc(0, 0, 0, 1, 0);
        chk("w8_unf_q2", got_q(2), 32'd255);
        chk("w8_unf2", {31'd0, unf2}, 32'd1);

        // randomized traffic, biased toward boundary loads
        for (int k = 0; k < 600; k++) begin
            bit r, l, e, u;
            int din;
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       din = 0;
                1:       din = 9;
                2:       din = 255;
                default: din = $urandom_range(0, 255);
            endcase
            cyc(r, l, din, e, u);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
